// File: rtl/dm_main_mem.sv
// Line-granular main-memory responder below the direct-mapped cache controller.
// Optional build macro DM_MAIN_MEM_PRELOAD_EN fills line i with {4{i}} at time 0.

package dm_main_mem_pkg;
  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;
endpackage

module dm_main_mem
  import dm_main_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              rw_q;
  cache_data_type    wdata_q;
  cache_data_type    rdata_q;
  logic              ready_q;

  logic [IDX_W-1:0]  req_idx;
  logic              unused_addr;

  // Byte offset and bits above the line index are dropped, so addresses alias.
  assign req_idx     = mem_req.addr[4 +: IDX_W];
  assign unused_addr = ^mem_req.addr;

`ifdef DM_MAIN_MEM_PRELOAD_EN
  typedef cache_data_type mem_array_t [DEPTH];

  function automatic mem_array_t preload_image();
    mem_array_t img;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = {4{i[31:0]}};
    end
    return img;
  endfunction

  mem_array_t mem_q = preload_image();
`else
  bit [127:0] mem_q [DEPTH];
`endif

  // The write lands on the edge leaving RESP; an async reset during RESP drops it.
  always_ff @(posedge clk) begin
    if (state_q == RESP && rw_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (mem_req.valid) begin
            idx_q   <= req_idx;
            rw_q    <= mem_req.rw;
            wdata_q <= mem_req.data;
            if (LATENCY == 1) begin
              cnt_q   <= '0;
              state_q <= RESP;
              ready_q <= 1'b1;
              rdata_q <= mem_req.rw ? mem_req.data : mem_q[req_idx];
            end else begin
              cnt_q   <= CNT_LOAD;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            rdata_q <= rw_q ? wdata_q : mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_data.data  = rdata_q;
  assign mem_data.ready = ready_q;

endmodule
